io_input_debounce: RTL and testbench
====================================

IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, stable-cycle count for commit (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, debounce counter width; SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 io_clk  input  1  sole clock; all state on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 sw  input  10  raw asynchronous slide switches; sw[4:0] is operand 0, sw[9:5] is operand 1.
REQ-006 key_mode  input  1  raw asynchronous pushbutton, active-low (0 = pressed).
REQ-007 in_port0  output  32  debounced operand 0, zero-extended; feeds the IO input register at 0x80.
REQ-008 in_port1  output  32  debounced operand 1, zero-extended; feeds the IO input register at 0x84.
REQ-009 and_model  output  1  mode flag; toggles once per debounced press; read at 0x8C.
REQ-010 in_changed  output  1  one-cycle pulse when in_port0/in_port1 commit a new value.
REQ-011 key_press  output  1  one-cycle pulse on each debounced key press.

Function
REQ-012 All 11 raw inputs SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-013 Switch path SHALL hold registers cand[9:0], stable[9:0], cnt[CNT_W-1:0].
- sync2 == stable: cand <= stable, cnt <= 0.
- sync2 != stable and sync2 != cand: cand <= sync2, cnt <= 0.
- sync2 == cand != stable, cnt == DEBOUNCE_CYCLES-1: stable <= cand, cnt <= 0, in_changed <= 1.
- otherwise: cnt <= cnt+1.
REQ-014 in_changed SHALL be 0 in every cycle with no commit; it is never high two consecutive cycles.
REQ-015 Latency: with sw changed before rising edge k and held constant, stable/in_port* SHALL show the new value after edge k+2+DEBOUNCE_CYCLES, with no earlier change.
REQ-016 Glitch rule: a sync2 value that returns to stable before commit SHALL cause no output change and no pulse.
REQ-017 in_port0 = {27'b0, stable[4:0]}; in_port1 = {27'b0, stable[9:5]}; upper 27 bits SHALL always be 0.
REQ-018 Key path SHALL use the same debounce algorithm at width 1 with a 2-state FSM: K_UP (debounced 1) and K_DOWN (debounced 0).
REQ-019 K_UP -> K_DOWN on commit of 0: key_press pulses 1 cycle and and_model inverts in the same edge. K_DOWN -> K_UP on commit of 1: no pulse, no toggle.
REQ-020 A key held indefinitely SHALL produce exactly one toggle; there is no auto-repeat.
REQ-021 Switch and key commits in the same cycle SHALL both take effect independently.
REQ-022 Counters SHALL never wrap; cnt never exceeds DEBOUNCE_CYCLES-1.

Reset
REQ-023 While resetn == 0 at a rising edge:
- sync flops, cand and stable for switches SHALL load 0;
- key sync, cand and stable SHALL load 1; FSM SHALL enter K_UP;
- all counters SHALL load 0; in_changed, key_press and and_model SHALL load 0.
REQ-024 Reset asserted mid-count SHALL abort the pending commit; after release, the debounce interval restarts from zero.
REQ-025 Switch levels present at reset release SHALL commit after the normal latency and pulse in_changed if nonzero.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (K_UP, K_DOWN) and the default debounce constants.
REQ-027 Sub-module debounce_cell (params WIDTH, DEBOUNCE_CYCLES, CNT_W, RESET_VAL) SHALL implement REQ-012/REQ-013. It SHALL be instantiated twice: WIDTH=10, RESET_VAL=0 and WIDTH=1, RESET_VAL=1.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, sw=0, key=1 -> in_port0=in_port1=0, and_model=0, no pulses for 20 cycles.
REQ-029 sw=10'b00011_00101 applied before edge k -> in_port0=5, in_port1=3 after edge k+6, in_changed high exactly 1 cycle.
REQ-030 sw toggles to 10'h3FF for 3 cycles, then returns -> outputs unchanged, in_changed never asserts.
REQ-031 key held 0 for 50 cycles, then released -> key_press 1 pulse, and_model 0->1 once. A second press -> and_model 1->0.
REQ-032 key bouncing 0/1 every 2 cycles for 20 cycles, then held 0 -> exactly one toggle, occurring DEBOUNCE_CYCLES+3 edges after the final bounce.
REQ-033 resetn pulsed low at cnt=2 of a pending switch change -> no commit before the full interval after release; and_model returns to 0.

Source files
------------

// File: rtl/io_input_debounce_pkg.sv
// Shared constants and key-FSM encoding for the switch/key debounce block.
package io_input_debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_CNT_W           = 16;

  typedef enum logic {
    K_UP   = 1'b0,
    K_DOWN = 1'b1
  } key_state_e;

endpackage

// File: rtl/io_input_debounce_debounce_cell.sv
// Two-flop synchronizer followed by a stable-count debouncer of WIDTH bits.
module debounce_cell #(
  parameter int       WIDTH           = 1,
  parameter int       DEBOUNCE_CYCLES = 50000,
  parameter int       CNT_W           = 16,
  parameter bit       RESET_VAL       = 1'b0
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             commit_now
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // commit_now is combinational so the caller can act on the same edge that updates stable
  always_comb begin
    commit_now = (sync2 == cand) && (cand != stable) &&
                 (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      sync1  <= {WIDTH{RESET_VAL}};
      sync2  <= {WIDTH{RESET_VAL}};
      cand   <= {WIDTH{RESET_VAL}};
      stable <= {WIDTH{RESET_VAL}};
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cand <= stable;
        cnt  <= '0;
      end else if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (commit_now) begin
        stable <= cand;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input_debounce.sv
// Debounced slide-switch operands and a toggling mode flag driven by a pushbutton.
module io_input_debounce
  import io_input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic        key_mode,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic        and_model,
  output logic        in_changed,
  output logic        key_press
);

  logic [9:0] sw_stable;
  logic       sw_commit;
  logic [0:0] key_stable;
  logic       key_commit;
  key_state_e key_state;

  debounce_cell #(
    .WIDTH          (10),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (1'b0)
  ) u_sw_cell (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .raw       (sw),
    .stable    (sw_stable),
    .commit_now(sw_commit)
  );

  debounce_cell #(
    .WIDTH          (1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (1'b1)
  ) u_key_cell (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .raw       (key_mode),
    .stable    (key_stable),
    .commit_now(key_commit)
  );

  assign in_port0 = {27'b0, sw_stable[4:0]};
  assign in_port1 = {27'b0, sw_stable[9:5]};

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      in_changed <= 1'b0;
    end else begin
      in_changed <= sw_commit;
    end
  end

  // Only the press (commit of 0) toggles the mode; release just re-arms the FSM
  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      key_state <= K_UP;
      key_press <= 1'b0;
      and_model <= 1'b0;
    end else begin
      key_press <= 1'b0;
      case (key_state)
        K_UP: begin
          if (key_commit && key_stable[0]) begin
            key_state <= K_DOWN;
            key_press <= 1'b1;
            and_model <= ~and_model;
          end
        end
        K_DOWN: begin
          if (key_commit && !key_stable[0]) begin
            key_state <= K_UP;
          end
        end
        default: key_state <= K_UP;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with DEBOUNCE_CYCLES=4.
module tb_io_input_debounce;

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [9:0]  sw;
  logic        key_mode;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        and_model;
  logic        in_changed;
  logic        key_press;

  io_input_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .sw        (sw),
    .key_mode  (key_mode),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .and_model (and_model),
    .in_changed(in_changed),
    .key_press (key_press)
  );

  always #5 io_clk = ~io_clk;

  int   chg_total = 0;
  int   kp_total  = 0;
  int   dbl_viol  = 0;
  logic prev_chg  = 1'b0;
  logic prev_kp   = 1'b0;

  always @(posedge io_clk) begin
    if (in_changed === 1'b1) chg_total++;
    if (key_press === 1'b1) kp_total++;
    if ((in_changed === 1'b1 && prev_chg) || (key_press === 1'b1 && prev_kp)) dbl_viol++;
    prev_chg = (in_changed === 1'b1);
    prev_kp  = (key_press === 1'b1);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  typedef struct {
    logic [9:0]  sw;
    logic        key;
    int          hold;
    logic [31:0] p0;
    logic [31:0] p1;
    logic        am;
    int          chg;
    int          kp;
  } vec_t;

  vec_t tbl[7];
  int   base_chg;
  int   base_kp;

  initial begin
    tbl[0] = '{10'h3FF, 1'b1, 8, 32'd31, 32'd31, 1'b0, 1, 0};
    tbl[1] = '{10'h21F, 1'b1, 8, 32'd31, 32'd16, 1'b0, 1, 0};
    tbl[2] = '{10'h21F, 1'b0, 8, 32'd31, 32'd16, 1'b1, 0, 1};
    tbl[3] = '{10'h21F, 1'b1, 8, 32'd31, 32'd16, 1'b1, 0, 0};
    tbl[4] = '{10'h1E0, 1'b0, 8, 32'd0,  32'd15, 1'b0, 1, 1};
    tbl[5] = '{10'h1E0, 1'b1, 8, 32'd0,  32'd15, 1'b0, 0, 0};
    tbl[6] = '{10'h000, 1'b1, 8, 32'd0,  32'd0,  1'b0, 1, 0};

    // reset and idle
    resetn   = 1'b0;
    sw       = 10'h000;
    key_mode = 1'b1;
    repeat (3) tick();
    check("rst_in_port0", in_port0, 32'd0);
    check("rst_in_port1", in_port1, 32'd0);
    check("rst_and_model", {31'b0, and_model}, 32'd0);
    check("rst_in_changed", {31'b0, in_changed}, 32'd0);
    check("rst_key_press", {31'b0, key_press}, 32'd0);
    resetn   = 1'b1;
    base_chg = chg_total;
    base_kp  = kp_total;
    repeat (20) tick();
    check("idle_chg_pulses", chg_total - base_chg, 0);
    check("idle_kp_pulses", kp_total - base_kp, 0);
    check("idle_in_port0", in_port0, 32'd0);

    // commit latency: change before edge k, visible after edge k+6
    sw       = 10'b00011_00101;
    base_chg = chg_total;
    repeat (6) tick();
    check("lat_early_p0", in_port0, 32'd0);
    check("lat_early_chg", {31'b0, in_changed}, 32'd0);
    tick();
    check("lat_p0", in_port0, 32'd5);
    check("lat_p1", in_port1, 32'd3);
    check("lat_chg_high", {31'b0, in_changed}, 32'd1);
    tick();
    check("lat_chg_low", {31'b0, in_changed}, 32'd0);
    check("lat_chg_pulses", chg_total - base_chg, 1);

    // short glitch is filtered
    base_chg = chg_total;
    sw       = 10'h3FF;
    repeat (3) tick();
    sw       = 10'b00011_00101;
    repeat (12) tick();
    check("glitch_p0", in_port0, 32'd5);
    check("glitch_p1", in_port1, 32'd3);
    check("glitch_chg_pulses", chg_total - base_chg, 0);

    for (int i = 0; i < 7; i++) begin
      base_chg = chg_total;
      base_kp  = kp_total;
      sw       = tbl[i].sw;
      key_mode = tbl[i].key;
      repeat (tbl[i].hold) tick();
      check($sformatf("tbl%0d_p0", i), in_port0, tbl[i].p0);
      check($sformatf("tbl%0d_p1", i), in_port1, tbl[i].p1);
      check($sformatf("tbl%0d_and", i), {31'b0, and_model}, {31'b0, tbl[i].am});
      check($sformatf("tbl%0d_chg", i), chg_total - base_chg, tbl[i].chg);
      check($sformatf("tbl%0d_kp", i), kp_total - base_kp, tbl[i].kp);
    end

    // long hold gives one toggle, second press toggles back
    base_kp  = kp_total;
    key_mode = 1'b0;
    repeat (50) tick();
    check("hold_kp_pulses", kp_total - base_kp, 1);
    check("hold_and", {31'b0, and_model}, 32'd1);
    key_mode = 1'b1;
    repeat (10) tick();
    check("release_kp_pulses", kp_total - base_kp, 1);
    check("release_and", {31'b0, and_model}, 32'd1);
    key_mode = 1'b0;
    repeat (10) tick();
    check("press2_and", {31'b0, and_model}, 32'd0);
    key_mode = 1'b1;
    repeat (10) tick();

    // bouncing key, then a settled press
    base_kp = kp_total;
    for (int i = 0; i < 10; i++) begin
      key_mode = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    check("bounce_and", {31'b0, and_model}, 32'd0);
    check("bounce_kp_pulses", kp_total - base_kp, 0);
    key_mode = 1'b0;
    repeat (6) tick();
    check("bounce_early_and", {31'b0, and_model}, 32'd0);
    tick();
    check("bounce_toggle_and", {31'b0, and_model}, 32'd1);
    check("bounce_toggle_kp", {31'b0, key_press}, 32'd1);
    repeat (20) tick();
    key_mode = 1'b1;
    repeat (10) tick();
    check("bounce_kp_total", kp_total - base_kp, 1);
    check("bounce_final_and", {31'b0, and_model}, 32'd1);

    // reset mid-count aborts and restarts the interval
    sw = 10'b00011_00101;
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    check("midrst_and", {31'b0, and_model}, 32'd0);
    check("midrst_p0", in_port0, 32'd0);
    resetn = 1'b1;
    repeat (6) tick();
    check("midrst_early_p0", in_port0, 32'd0);
    tick();
    check("midrst_p0_commit", in_port0, 32'd5);
    check("midrst_p1_commit", in_port1, 32'd3);
    check("midrst_chg", {31'b0, in_changed}, 32'd1);
    check("midrst_and_after", {31'b0, and_model}, 32'd0);
    repeat (3) tick();

    check("no_double_pulse", dbl_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
